// File: rtl/sparrow_pkg.sv
// Shared types for the sparrow fetch slice: buffer entry layout and fetch FSM states.
package sparrow_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } ifetch_entry_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StStall = 2'd2
    } ifetch_state_e;

endpackage

// File: rtl/sparrow_fifo.sv
// First-word-fall-through buffer with synchronous flush; entry type is a parameter.
module sparrow_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    output entry_t                 data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sparrow_ifetch.sv
// Credit-based instruction fetch with redirect flush and in-order response discard.
// Optional misaligned-redirect fault entry: SPARROW_IFETCH_ALIGN_CHECK_EN.
module sparrow_ifetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
    output logic            instr_fault_o,
`endif
    input  logic            instr_ready_i
);
    import sparrow_pkg::*;

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ifetch_state_e   state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc_q, tag_pc_d;
    logic [CW-1:0]   outst_q, outst_d, discard_q, discard_d;
    logic [CW-1:0]   fifo_count, count_next, credits, credits_next;
    logic            fifo_full, fifo_empty;
    logic            grant, pop, push, rsp_keep, fault_push, fetch_block, fetch_block_d;
    ifetch_entry_t   push_entry, head;

    assign grant     = mem_req_o && mem_gnt_i;
    assign pop       = instr_valid_o && instr_ready_i && !redirect_valid_i;
    assign rsp_keep  = mem_rvalid_i && (discard_q == '0) && !redirect_valid_i;
    assign push      = rsp_keep || fault_push;
    // Credits cover buffered words plus responses still in flight, so the buffer cannot overflow.
    assign credits   = DEPTH_C - fifo_count - outst_q;
    assign mem_req_o = (state_q == StFetch) && (credits != '0) && !redirect_valid_i && !fetch_block;
    assign mem_addr_o = {fetch_pc_q[XLEN-1:2], 2'b00};

    always_comb begin
        push_entry = '{instr: mem_rdata_i, pc: tag_pc_q, fault: 1'b0};
        if (fault_push) begin
            push_entry = '{instr: '0, pc: fetch_pc_q, fault: 1'b1};
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(grant) - CW'(mem_rvalid_i);
        if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (mem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if (rsp_keep) begin
            tag_pc_d = tag_pc_q + XLEN'(4);
        end
        // Everything still outstanding after this cycle belongs to the abandoned stream.
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            tag_pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
            discard_d  = outst_d;
        end
    end

    assign count_next   = redirect_valid_i ? '0 : fifo_count + CW'(push) - CW'(pop);
    assign credits_next = DEPTH_C - count_next - outst_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if ((credits_next == '0) || fetch_block_d) state_d = StStall;
            StStall: if ((credits_next != '0) && !fetch_block_d) state_d = StFetch;
            default: state_d = StIdle;
        endcase
        if (redirect_valid_i) begin
            state_d = StFetch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
    logic pend_q, pend_d, halt_q, halt_d;

    // A misaligned redirect waits for old responses to drain, emits one fault entry, then halts.
    always_comb begin
        pend_d     = pend_q;
        halt_d     = halt_q;
        fault_push = pend_q && (discard_q == '0) && !redirect_valid_i;
        if (fault_push) begin
            pend_d = 1'b0;
            halt_d = 1'b1;
        end
        if (redirect_valid_i) begin
            pend_d = |redirect_pc_i[1:0];
            halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            halt_q <= halt_d;
        end
    end

    assign fetch_block   = pend_q || halt_q;
    assign fetch_block_d = pend_d || halt_d;
    assign instr_fault_o = instr_valid_o && head.fault;
`else
    logic unused_bits;

    assign fault_push    = 1'b0;
    assign fetch_block   = 1'b0;
    assign fetch_block_d = 1'b0;
    assign unused_bits   = head.fault ^ (^fetch_pc_q[1:0]);
`endif

    sparrow_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ifetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

    overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sparrow_ifetch.sv
// Directed bench for sparrow_ifetch with an in-order memory model (1-cycle response latency).
module tb_sparrow_ifetch;
    localparam logic [31:0] KEY = 32'hA500_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
    logic        instr_fault_o;
`endif

    int          passed = 0;
    int          total = 0;
    logic [31:0] pend[$];
    logic [31:0] seen[$];
    int          grant_cnt = 0;
    logic [31:0] last_gnt_addr = '0;
    bit          resp_en = 1'b1;

    sparrow_ifetch #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
        .instr_fault_o    (instr_fault_o),
`endif
        .instr_ready_i    (instr_ready_i)
    );

    always #5 clk = ~clk;

    // Memory: answers the oldest earlier grant, then records this cycle's grant.
    always @(negedge clk) begin
        mem_rvalid_i = 1'b0;
        if (!reset_n) begin
            pend.delete();
        end else begin
            if (resp_en && pend.size() > 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend[0] ^ KEY;
                void'(pend.pop_front());
            end
            if (mem_req_o && mem_gnt_i) begin
                pend.push_back(mem_addr_o);
                grant_cnt++;
                last_gnt_addr = mem_addr_o;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && instr_valid_o && instr_ready_i && !redirect_valid_i) begin
            seen.push_back(instr_pc_o);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic g, input logic r);
        reset_n          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mem_gnt_i        = g;
        instr_ready_i    = r;
        resp_en          = 1'b1;
        step(2);
        seen.delete();
        grant_cnt = 0;
        reset_n   = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        step(6);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req_o); else passed++;
        total++; if (mem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr_o); else passed++;
        total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid_o); else passed++;
        total++; if (instr_o !== 32'h0 || instr_pc_o !== 32'h0)
            $display("FAIL reset_head: got instr %h pc %h want 0 0", instr_o, instr_pc_o); else passed++;
`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
        total++; if (instr_fault_o !== 1'b0) $display("FAIL reset_fault: got %b want 0", instr_fault_o); else passed++;
`endif
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b1);
        total++; if (mem_req_o !== 1'b0) $display("FAIL stream_req_t0: got %b want 0", mem_req_o); else passed++;
        step(1);
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0)
            $display("FAIL stream_req_t1: got %b/%h want 1/0", mem_req_o, mem_addr_o); else passed++;
        step(2);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(4 * k) || instr_o !== (32'(4 * k) ^ KEY))
                $display("FAIL stream_pc%0d: got v%b pc %h instr %h want v1 pc %h", k, instr_valid_o,
                         instr_pc_o, instr_o, 32'(4 * k));
            else passed++;
            step(1);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b1, 1'b0);
        step(12);
        total++; if (grant_cnt !== 4) $display("FAIL bp_grants: got %0d want 4", grant_cnt); else passed++;
        total++; if (mem_req_o !== 1'b0) $display("FAIL bp_req_low: got %b want 0", mem_req_o); else passed++;
        total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0)
            $display("FAIL bp_head: got v%b pc %h want v1 pc 0", instr_valid_o, instr_pc_o); else passed++;
        instr_ready_i = 1'b1;
        step(1);
        instr_ready_i = 1'b0;
        total++; if (instr_pc_o !== 32'h4) $display("FAIL bp_pop: got pc %h want 4", instr_pc_o); else passed++;
        step(8);
        total++; if (grant_cnt !== 5 || last_gnt_addr !== 32'h10)
            $display("FAIL bp_one_more: got %0d grants last %h want 5 last 10", grant_cnt, last_gnt_addr);
        else passed++;
        total++; if (mem_req_o !== 1'b0) $display("FAIL bp_req_low2: got %b want 0", mem_req_o); else passed++;
    endtask

    task automatic test_gnt_stall();
        do_reset(1'b1, 1'b1);
        step(5);
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10)
                $display("FAIL hold_cyc%0d: got %b/%h want 1/10", i, mem_req_o, mem_addr_o);
            else passed++;
            step(1);
        end
        mem_gnt_i = 1'b1;
        step(1);
        total++; if (mem_addr_o !== 32'h14 || last_gnt_addr !== 32'h10)
            $display("FAIL hold_next: got addr %h last grant %h want 14/10", mem_addr_o, last_gnt_addr);
        else passed++;
    endtask

    task automatic test_redirect();
        int bad;
        do_reset(1'b1, 1'b0);
        resp_en = 1'b0;
        step(4);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h100;
        #1;
        total++; if (mem_req_o !== 1'b0) $display("FAIL redir_req: got %b want 0", mem_req_o); else passed++;
        step(1);
        redirect_valid_i = 1'b0;
        resp_en          = 1'b1;
        instr_ready_i    = 1'b1;
        total++; if (instr_valid_o !== 1'b0) $display("FAIL redir_flush: got %b want 0", instr_valid_o); else passed++;
        step(15);
        total++; if (seen[0] !== 32'h100 || seen[1] !== 32'h104 || seen[2] !== 32'h108)
            $display("FAIL redir_first: got %h %h %h want 100 104 108", seen[0], seen[1], seen[2]);
        else passed++;
        bad = 0;
        foreach (seen[i]) if (seen[i] < 32'h100) bad++;
        total++; if (bad !== 0) $display("FAIL redir_stale: got %0d stale pcs want 0", bad); else passed++;
    endtask

    task automatic test_collide();
        do_reset(1'b1, 1'b1);
        step(5);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h200;
        #1;
        total++; if (mem_req_o !== 1'b0) $display("FAIL coll_req: got %b want 0", mem_req_o); else passed++;
        step(1);
        redirect_valid_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0) $display("FAIL coll_flush: got %b want 0", instr_valid_o); else passed++;
        step(10);
        total++;
        if (seen.size() < 5 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h200 ||
            seen[3] !== 32'h204 || seen[4] !== 32'h208)
            $display("FAIL coll_seq: got %0d pcs %h %h %h %h %h want 0 4 200 204 208", seen.size(),
                     seen[0], seen[1], seen[2], seen[3], seen[4]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset(1'b1, 1'b0);
        resp_en = 1'b0;
        step(3);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h300;
        step(1);
        redirect_pc_i = 32'h400;
        resp_en       = 1'b1;
        step(1);
        redirect_valid_i = 1'b0;
        instr_ready_i    = 1'b1;
        step(15);
        total++; if (seen[0] !== 32'h400 || seen[1] !== 32'h404)
            $display("FAIL b2b_first: got %h %h want 400 404", seen[0], seen[1]);
        else passed++;
        bad = 0;
        foreach (seen[i]) if (seen[i] < 32'h400) bad++;
        total++; if (bad !== 0 || seen.size() < 8)
            $display("FAIL b2b_stale: got %0d stale of %0d want 0 of >=8", bad, seen.size());
        else passed++;
    endtask

`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
    task automatic test_align();
        int gc;
        do_reset(1'b1, 1'b0);
        step(3);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h102;
        step(1);
        redirect_valid_i = 1'b0;
        gc = grant_cnt;
        step(6);
        total++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h102 || instr_fault_o !== 1'b1 || instr_o !== 32'h0)
            $display("FAIL align_entry: got v%b pc %h f%b instr %h want v1 pc 102 f1 instr 0",
                     instr_valid_o, instr_pc_o, instr_fault_o, instr_o);
        else passed++;
        instr_ready_i = 1'b1;
        step(1);
        instr_ready_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0) $display("FAIL align_single: got %b want 0", instr_valid_o); else passed++;
        step(3);
        total++; if (grant_cnt !== gc || mem_req_o !== 1'b0)
            $display("FAIL align_halt: got %0d grants req %b want %0d req 0", grant_cnt, mem_req_o, gc);
        else passed++;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h200;
        step(1);
        redirect_valid_i = 1'b0;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200)
            $display("FAIL align_resume: got %b/%h want 1/200", mem_req_o, mem_addr_o);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_collide();
        test_back_to_back();
`ifdef SPARROW_IFETCH_ALIGN_CHECK_EN
        test_align();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
